// File: rtl/ccff_chain_loader_pkg.sv
// Shared definitions for the ccff configuration-chain loader: FSM states and fabric chain sizing.
package ccff_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_MARK,
        S_PROBE,
        S_FINISH
    } state_t;

    localparam int unsigned FABRIC_CHAIN_LEN = 36;
    localparam int unsigned DEFAULT_MAX_LEN  = 64;

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Byte-stream valid/ready channel carrying the configuration bitstream into the loader.
interface ccff_chain_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, in_data, input in_ready);
    modport slave  (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/ccff_chain_loader_byte_serializer.sv
// 8-bit MSB-first shift register with a remaining-bit count; load takes priority over shift.
module ccff_byte_serializer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift,
    output logic       msb,
    output logic       empty,
    output logic [3:0] left
);

    logic [7:0] sr;

    // A load in the same cycle as the last bit's shift replaces the spent bit.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sr   <= '0;
            left <= '0;
        end else if (load) begin
            sr   <= load_data;
            left <= 4'd8;
        end else if (shift && left != 4'd0) begin
            sr   <= {sr[6:0], 1'b0};
            left <= left - 4'd1;
        end
    end

    assign msb   = sr[7];
    assign empty = (left == 4'd0);

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises a byte stream onto the ccff configuration chain and probes the chain length via ccff_tail.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = FABRIC_CHAIN_LEN,
    parameter int unsigned MAX_LEN   = DEFAULT_MAX_LEN,
    parameter int unsigned CNT_W     = $clog2(MAX_LEN + 1) + 1
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset_n,
    input  logic                 start_load,
    input  logic                 start_probe,
    ccff_chain_loader_if.slave   in_bus,
    output logic                 ccff_head,
    output logic                 chain_clk_en,
    input  logic                 ccff_tail,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     probe_len,
    output logic                 probe_ok,
    output logic                 probe_timeout
);

    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] MAX_LEN_C   = CNT_W'(MAX_LEN);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             in_ready;
    logic             ser_load, ser_shift, ser_msb, ser_empty;
    logic [3:0]       ser_left;

    ccff_byte_serializer u_ser (
        .clk       (prog_clk),
        .rst_n     (prog_reset_n),
        .clear     (state != S_LOAD),
        .load      (ser_load),
        .load_data (in_bus.in_data),
        .shift     (ser_shift),
        .msb       (ser_msb),
        .empty     (ser_empty),
        .left      (ser_left)
    );

    assign in_bus.in_ready = in_ready;
    assign busy            = (state != S_IDLE);
    assign done            = (state == S_FINISH);

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) state <= S_IDLE;
        else               state <= next_state;
    end

    always_comb begin
        next_state   = state;
        in_ready     = 1'b0;
        ccff_head    = 1'b0;
        chain_clk_en = 1'b0;
        ser_load     = 1'b0;
        ser_shift    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_load)       next_state = S_LOAD;
                else if (start_probe) next_state = S_FLUSH;
            end
            S_LOAD: begin
                // cnt counts bits already sent; a byte is taken only if more bits are still owed.
                ser_shift    = !ser_empty;
                ccff_head    = ser_shift & ser_msb;
                chain_clk_en = ser_shift;
                in_ready     = (ser_empty || (ser_left == 4'd1 && ser_shift)) &&
                               ((cnt + CNT_W'(ser_left)) < CHAIN_LEN_C);
                ser_load     = in_bus.in_valid && in_ready;
                if (ser_shift && cnt == CHAIN_LEN_C - 1'b1) next_state = S_FINISH;
            end
            S_FLUSH: begin
                chain_clk_en = 1'b1;
                if (cnt == MAX_LEN_C - 1'b1) next_state = S_MARK;
            end
            S_MARK: begin
                ccff_head    = 1'b1;
                chain_clk_en = 1'b1;
                next_state   = S_PROBE;
            end
            S_PROBE: begin
                if (ccff_tail || cnt == MAX_LEN_C) next_state = S_FINISH;
                else                               chain_clk_en = 1'b1;
            end
            S_FINISH: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            cnt           <= '0;
            probe_len     <= '0;
            probe_ok      <= 1'b0;
            probe_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start_probe && !start_load) begin
                        probe_len     <= '0;
                        probe_ok      <= 1'b0;
                        probe_timeout <= 1'b0;
                    end
                end
                S_LOAD:  if (chain_clk_en) cnt <= cnt + 1'b1;
                S_FLUSH: cnt <= cnt + 1'b1;
                S_MARK:  cnt <= CNT_W'(1);
                S_PROBE: begin
                    if (ccff_tail) begin
                        probe_len <= cnt;
                        probe_ok  <= (cnt == CHAIN_LEN_C);
                    end else if (cnt == MAX_LEN_C) begin
                        probe_len     <= MAX_LEN_C;
                        probe_ok      <= (MAX_LEN_C == CHAIN_LEN_C);
                        probe_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Host-side driver for the configuration-chain flip-flop (ccff) shift chain that runs through every switch block and connection block in the fabric.
- Accepts a configuration bitstream as a byte stream and serialises it MSB-first onto ccff_head.
- Issues a per-bit shift enable for the fabric's gated configuration clock.
- Also provides a chain-length probe that watches ccff_tail returning from the far end of the chain.

Parameters:
- CHAIN_LEN, 36: configuration bits shifted per load.
- MAX_LEN, 64: probe flush length and probe timeout bound; must be >= CHAIN_LEN.
- CNT_W, $clog2(MAX_LEN+1)+1: counter width.

Ports:
- prog_clk  in  1  configuration clock (free-running).
- prog_reset_n  in  1  synchronous active-low reset.
- start_load  in  1  one-cycle pulse; begin a load.
- start_probe  in  1  one-cycle pulse; begin a probe.
- in_valid  in  1  byte available.
- in_data  in  8  bitstream byte, MSB shifted first.
- in_ready  out  1  byte accepted when in_valid and in_ready are both high.
- ccff_head  out  1  serial data into the first chain flop.
- chain_clk_en  out  1  fabric chain flops capture ccff_head at the prog_clk edge ending any cycle in which this is high.
- ccff_tail  in  1  output of the last chain flop.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse when a load or probe completes.
- probe_len  out  CNT_W  measured chain length.
- probe_ok  out  1  probe_len == CHAIN_LEN.
- probe_timeout  out  1  marker never returned.

Behaviour:
- Reset, taken at a prog_clk edge with prog_reset_n low, from any state:
  - State goes to IDLE.
  - All outputs go to 0: in_ready, ccff_head, chain_clk_en, busy, done, probe_len, probe_ok, probe_timeout.
  - Counters and byte buffer are cleared.
  - Chain contents are undefined afterwards; the host must reload.
- States: IDLE, LOAD, FLUSH, MARK, PROBE, FINISH.
- IDLE:
  - start_load goes to LOAD with the bit counter at 0.
  - Otherwise start_probe goes to FLUSH.
  - start_load wins if both are high.
  - Starts arriving in any other state are ignored.
- LOAD, byte buffer (8-bit shift register plus a remaining-bit count):
  - in_ready = (buffer empty, or exactly 1 bit remaining and it shifts this cycle) and bits_sent + bits_buffered < CHAIN_LEN.
  - When the buffer holds a bit: ccff_head = buffer MSB, chain_clk_en = 1, buffer shifts left, bits_sent increments.
  - When the buffer is empty (host stall): chain_clk_en = 0 and the chain holds.
  - Byte accepted in cycle N: its first bit is on ccff_head in cycle N+1. Back-to-back bytes give one bit per cycle with no bubble.
  - When the final byte exceeds the remaining bits, only the top (CHAIN_LEN mod 8) bits are shifted and the low bits are discarded.
  - After the shift that makes bits_sent = CHAIN_LEN, go to FINISH. in_ready stays 0 from that point.
- FLUSH:
  - Shift exactly MAX_LEN zeros (chain_clk_en = 1 every cycle, ccff_head = 0), then go to MARK.
- MARK:
  - One cycle: ccff_head = 1, chain_clk_en = 1, probe counter set to 1, go to PROBE.
- PROBE, each cycle:
  - If ccff_tail = 1: probe_len = counter, go to FINISH, no shift this cycle.
  - Else if counter = MAX_LEN: set probe_timeout, probe_len = MAX_LEN, go to FINISH.
  - Else shift a 0 and increment the counter.
  - Result: a chain of length L reports probe_len = L.
- Probe side effect: the probe destroys the configuration; a reload is required.
- FINISH:
  - done = 1 for one cycle, then IDLE.
  - probe_ok, probe_len and probe_timeout are registered at the FINISH transition and held until the next start_probe, which clears them.
  - A load does not alter probe results.
- Counters are unsigned CNT_W bits and never wrap; the MAX_LEN bound stops them.

Decomposition:
- Shared package ccff_pkg holds:
  - the state enum;
  - CHAIN_LEN for the fabric;
  - default MAX_LEN.
- One natural sub-module, ccff_byte_serializer: an 8-bit MSB-first shift register with remaining-count, load/shift ports and an empty flag.
- FSM and counters stay in the top module.

Test Plan:
- Bench model: an N-bit shift register clocked by prog_clk when chain_clk_en is high.
- Load, N = 36, bytes 0xA5 0x3C 0xFF 0x00 0x9F, in_valid always high:
  - Model holds 0xA53CFF009 (first bit deepest).
  - chain_clk_en high exactly 36 consecutive cycles; 5 bytes accepted; done pulses once.
- Same load with in_valid low for 3 cycles after each byte:
  - Identical final chain.
  - chain_clk_en low during each stall gap; total enables = 36.
- Probe, N = 36: probe_len = 36, probe_ok = 1, probe_timeout = 0, total enables = 64 + 36.
- Probe, N = 40: probe_len = 40, probe_ok = 0.
- Probe with ccff_tail tied 0: probe_timeout = 1, probe_len = 64.
- Reset and start handling:
  - prog_reset_n low at bit 20 of a load gives busy = 0, chain_clk_en = 0, in_ready = 0 after the edge; a new load then completes correctly.
  - start_probe during a load is ignored.
  - Simultaneous start_load and start_probe in IDLE runs a load.
